// File: rtl/spc700_muldiv.sv
// SPC700 MUL/DIV unit: 8-step shift-add multiply and 9-step hardware-accurate divide.
// Define SPC700_MULDIV_FASTMUL_EN to compute MUL in a single cycle (DIV unchanged).
//
// state | meaning
// IDLE  | waiting for START, results held
// MUL   | multiply iterations in progress
// DIV   | divide iterations in progress
// FIN   | publish results, DONE on the next enabled edge, may accept START
module spc700_muldiv (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       START,
  input  logic       OP,
  input  logic [7:0] A_IN,
  input  logic [7:0] Y_IN,
  input  logic [7:0] X_IN,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] A_OUT,
  output logic [7:0] Y_OUT,
  output logic       NO,
  output logic       ZO,
  output logic       VO,
  output logic       HO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        op_q;
  logic        h_pend_q;
  logic [7:0]  mplier_q;
  logic [15:0] mcand_q;
  logic [15:0] acc_q;
  logic [16:0] yva_q;
  logic [16:0] xs_q;

  logic        busy_q;
  logic        done_q;
  logic [7:0]  a_out_q;
  logic [7:0]  y_out_q;
  logic        n_q;
  logic        z_q;
  logic        v_q;
  logic        h_q;

  logic        accept;
  logic [16:0] rot;
  logic [16:0] rot_x;
  logic [16:0] yva_d;
  logic [15:0] acc_d;

  logic [7:0]  res_a;
  logic [7:0]  res_y;
  logic        res_n;
  logic        res_z;
  logic        res_v;
  logic        res_h;

  // One divide step: 17-bit rotate, conditional quotient-bit flip, conditional subtract.
  always_comb begin
    rot   = {yva_q[15:0], yva_q[16]};
    rot_x = rot;
    if (rot >= xs_q) begin
      rot_x[0] = ~rot[0];
    end
    yva_d = rot_x[0] ? (rot_x - xs_q) : rot_x;
`ifdef SPC700_MULDIV_FASTMUL_EN
    acc_d = {8'h00, mcand_q[7:0]} * {8'h00, mplier_q};
`else
    acc_d = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
`endif
  end

  always_comb begin
    res_a = acc_q[7:0];
    res_y = acc_q[15:8];
    res_n = acc_q[15];
    res_z = (acc_q[15:8] == 8'h00);
    res_v = 1'b0;
    res_h = 1'b0;
    if (op_q) begin
      res_a = yva_q[7:0];
      res_y = yva_q[16:9];
      res_v = yva_q[8];
      res_h = h_pend_q;
      res_n = yva_q[7];
      res_z = (yva_q[7:0] == 8'h00);
    end
  end

  // FIN accepts START like IDLE so consecutive operations run without a gap.
  assign accept = START && ((state_q == S_IDLE) || (state_q == S_FIN));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      op_q     <= 1'b0;
      h_pend_q <= 1'b0;
      mplier_q <= 8'h00;
      mcand_q  <= 16'h0000;
      acc_q    <= 16'h0000;
      yva_q    <= 17'h00000;
      xs_q     <= 17'h00000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      a_out_q  <= 8'h00;
      y_out_q  <= 8'h00;
      n_q      <= 1'b0;
      z_q      <= 1'b1;
      v_q      <= 1'b0;
      h_q      <= 1'b0;
    end else if (EN) begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          state_q <= S_IDLE;
        end
        S_MUL: begin
`ifdef SPC700_MULDIV_FASTMUL_EN
          acc_q   <= acc_d;
          state_q <= S_FIN;
          busy_q  <= 1'b0;
`else
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[14:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[7:1]};
          cnt_q    <= cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
          end
`endif
        end
        S_DIV: begin
          yva_q <= yva_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd8) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          a_out_q <= res_a;
          y_out_q <= res_y;
          n_q     <= res_n;
          z_q     <= res_z;
          v_q     <= res_v;
          h_q     <= res_h;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (accept) begin
        op_q     <= OP;
        cnt_q    <= 4'd0;
        mplier_q <= A_IN;
        mcand_q  <= {8'h00, Y_IN};
        acc_q    <= 16'h0000;
        yva_q    <= {1'b0, Y_IN, A_IN};
        xs_q     <= {X_IN, 9'h000};
        h_pend_q <= (Y_IN[3:0] >= X_IN[3:0]);
        state_q  <= OP ? S_DIV : S_MUL;
        busy_q   <= 1'b1;
      end
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign A_OUT = a_out_q;
  assign Y_OUT = y_out_q;
  assign NO    = n_q;
  assign ZO    = z_q;
  assign VO    = v_q;
  assign HO    = h_q;

endmodule

// File: tb/tb_spc700_muldiv.sv
// Directed + random scoreboard bench for spc700_muldiv.
module tb_spc700_muldiv;
`ifdef SPC700_MULDIV_FASTMUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 9;
`endif
  localparam int DIV_LAT = 10;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] y;
    logic       n;
    logic       z;
    logic       v;
    logic       h;
  } res_t;

  logic       CLK = 1'b0;
  logic       RST, EN, START, OP;
  logic [7:0] A_IN, Y_IN, X_IN;
  logic       BUSY, DONE, NO, ZO, VO, HO;
  logic [7:0] A_OUT, Y_OUT;

  int   vectors = 0;
  int   miscompares = 0;
  int   edge_n = 0;
  int   start_edge = 0;
  res_t exp_q[$];
  res_t last_res;

  spc700_muldiv dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START), .OP(OP),
    .A_IN(A_IN), .Y_IN(Y_IN), .X_IN(X_IN),
    .BUSY(BUSY), .DONE(DONE), .A_OUT(A_OUT), .Y_OUT(Y_OUT),
    .NO(NO), .ZO(ZO), .VO(VO), .HO(HO)
  );

  always #5 CLK = ~CLK;

  function automatic res_t mk(input logic [7:0] a, input logic [7:0] y,
                              input logic n, input logic z, input logic v, input logic h);
    res_t r;
    r.a = a; r.y = y; r.n = n; r.z = z; r.v = v; r.h = h;
    return r;
  endfunction

  function automatic res_t mul_exp(input logic [7:0] a, input logic [7:0] y);
    logic [15:0] p;
    p = 16'(y) * 16'(a);
    return mk(p[7:0], p[15:8], p[15], p[15:8] == 8'h00, 1'b0, 1'b0);
  endfunction

  // Non-overflowing divide only (Y < X, X != 0): plain quotient/remainder.
  function automatic res_t div_exp(input logic [7:0] a, input logic [7:0] y, input logic [7:0] x);
    logic [15:0] q, r;
    q = {y, a} / 16'(x);
    r = {y, a} % 16'(x);
    return mk(q[7:0], r[7:0], q[7], q[7:0] == 8'h00, 1'b0, y[3:0] >= x[3:0]);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    edge_n++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic op, input logic [7:0] a, input logic [7:0] y,
                       input logic [7:0] x, input res_t e);
    START = 1'b1; OP = op; A_IN = a; Y_IN = y; X_IN = x;
    exp_q.push_back(e);
    tick();
    start_edge = edge_n;
    START = 1'b0;
    A_IN = 8'($urandom); Y_IN = 8'($urandom); X_IN = 8'($urandom); OP = 1'($urandom);
  endtask

  task automatic check_result(input string tag);
    res_t e;
    check({tag, " queued"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, " DONE"}, 32'(DONE), 32'd1);
      check({tag, " A_OUT"}, 32'(A_OUT), 32'(e.a));
      check({tag, " Y_OUT"}, 32'(Y_OUT), 32'(e.y));
      check({tag, " NO"}, 32'(NO), 32'(e.n));
      check({tag, " ZO"}, 32'(ZO), 32'(e.z));
      check({tag, " VO"}, 32'(VO), 32'(e.v));
      check({tag, " HO"}, 32'(HO), 32'(e.h));
      last_res = e;
    end
  endtask

  task automatic wait_done(input string tag, input int lat);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (DONE !== 1'b1 && n < 64);
    check({tag, " latency"}, 32'(edge_n - start_edge), 32'(lat));
    check_result(tag);
  endtask

  initial begin
    int dones;
    logic       op;
    logic [7:0] a, y, x;

    RST = 1'b1; EN = 1'b0; START = 1'b0; OP = 1'b0;
    A_IN = 8'h00; Y_IN = 8'h00; X_IN = 8'h00;

    // Reset with EN low: reset must still take effect.
    tick(); tick();
    check("reset BUSY", 32'(BUSY), 32'd0);
    check("reset DONE", 32'(DONE), 32'd0);
    check("reset A_OUT", 32'(A_OUT), 32'h00);
    check("reset Y_OUT", 32'(Y_OUT), 32'h00);
    check("reset flags NZVH", 32'({NO, ZO, VO, HO}), 32'b0100);

    // START on the first edge after reset release.
    RST = 1'b0; EN = 1'b1;
    issue(1'b0, 8'h34, 8'h12, 8'h00, mk(8'hA8, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0));
    check("mul BUSY", 32'(BUSY), 32'd1);
    check("mul outputs held", 32'(A_OUT), 32'h00);
    wait_done("mul 12x34", MUL_LAT);
    tick();
    check("DONE pulse", 32'(DONE), 32'd0);
    check("held A_OUT", 32'(A_OUT), 32'hA8);

    issue(1'b1, 8'h64, 8'h00, 8'h0A, mk(8'h0A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_done("div 100/10", DIV_LAT);
    issue(1'b1, 8'h00, 8'h00, 8'h00, mk(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1));
    wait_done("div by zero", DIV_LAT);
    issue(1'b1, 8'h00, 8'h20, 8'h10, mk(8'hFF, 8'h10, 1'b1, 1'b0, 1'b1, 1'b1));
    wait_done("div overflow", DIV_LAT);

    // Back-to-back: second START lands on the FIN edge of the first op.
    issue(1'b0, 8'hFF, 8'hFF, 8'h00, mul_exp(8'hFF, 8'hFF));
    repeat (MUL_LAT - 1) tick();
    issue(1'b1, 8'h00, 8'h01, 8'h20, div_exp(8'h00, 8'h01, 8'h20));
    check_result("b2b mul");
    check("b2b BUSY", 32'(BUSY), 32'd1);
    wait_done("b2b div", DIV_LAT);

    // EN low for three cycles mid-DIV, plus a START during BUSY that must be ignored.
    issue(1'b1, 8'hC8, 8'h05, 8'h33, div_exp(8'hC8, 8'h05, 8'h33));
    repeat (3) tick();
    EN = 1'b0;
    repeat (3) tick();
    check("EN low BUSY", 32'(BUSY), 32'd1);
    check("EN low DONE", 32'(DONE), 32'd0);
    check("EN low A_OUT", 32'(A_OUT), 32'(last_res.a));
    EN = 1'b1;
    START = 1'b1; OP = 1'b0; A_IN = 8'h02; Y_IN = 8'h02;
    tick();
    START = 1'b0;
    wait_done("div EN stall", DIV_LAT + 3);
    dones = 0;
    repeat (12) begin
      tick();
      if (DONE === 1'b1) dones++;
    end
    check("ignored START no DONE", 32'(dones), 32'd0);

    // Reset mid-MUL aborts without DONE; a START right after completes.
    issue(1'b0, 8'h77, 8'h99, 8'h00, mul_exp(8'h77, 8'h99));
    repeat ((MUL_LAT > 4) ? 4 : 1) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    void'(exp_q.pop_back());
    check("abort BUSY", 32'(BUSY), 32'd0);
    check("abort DONE", 32'(DONE), 32'd0);
    check("abort ZO", 32'(ZO), 32'd1);
    check("abort A_OUT", 32'(A_OUT), 32'h00);
    issue(1'b0, 8'h10, 8'h10, 8'h00, mk(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_done("mul after abort", MUL_LAT);

    for (int i = 0; i < 12; i++) begin
      op = 1'(i % 2);
      a = 8'($urandom);
      y = 8'($urandom);
      if (op) begin
        x = 8'($urandom_range(1, 255));
        y = 8'($urandom_range(0, int'(x) - 1));
        issue(op, a, y, x, div_exp(a, y, x));
        wait_done("rand div", DIV_LAT);
      end else begin
        issue(op, a, y, 8'h00, mul_exp(a, y));
        wait_done("rand mul", MUL_LAT);
      end
    end
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
